// File: rtl/img_meta_pkg.sv
// Shared definitions for the image metadata serializer: default header layout and FSM states.
package img_meta_pkg;

  // Default header layout, LSB first: trigger_index, timestamp, cam_id, RGB, compression.
  localparam int unsigned TRIG_W   = 16;
  localparam int unsigned TS_W     = 28;
  localparam int unsigned CAM_W    = 1;
  localparam int unsigned RGB_W    = 1;
  localparam int unsigned COMP_W   = 2;

  localparam int unsigned TRIG_OFF = 0;
  localparam int unsigned TS_OFF   = TRIG_OFF + TRIG_W;
  localparam int unsigned CAM_OFF  = TS_OFF + TS_W;
  localparam int unsigned RGB_OFF  = CAM_OFF + CAM_W;
  localparam int unsigned COMP_OFF = RGB_OFF + RGB_W;

  localparam int unsigned META_W_DEFAULT = COMP_OFF + COMP_W;

  typedef enum logic {
    StIdle,
    StSend
  } state_e;

endpackage

// File: rtl/img_meta_fifo.sv
// Synchronous FIFO holding queued metadata headers; rdata shows the head entry.
module img_meta_fifo #(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       sysClk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign count   = cnt_q;
  assign rdata   = mem[rd_q];
  assign do_pop  = pop && !empty;
  // A pop frees a slot in the same cycle, so a push into a full FIFO is accepted then.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge sysClk) begin
    if (do_push) begin
      mem[wr_q] <= wdata;
    end
  end

  always_ff @(posedge sysClk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/img_metadata_serializer.sv
// Queues metadata headers and streams each as MSB-first DATA_W beats on a pixel-done edge.
// Define IMG_META_CRC_EN to append an XOR check beat after the header beats.
module img_metadata_serializer
  import img_meta_pkg::*;
#(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned META_W = META_W_DEFAULT,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       sysClk,
  input  logic                       rst,
  input  logic [META_W-1:0]          meta_in,
  input  logic                       meta_valid,
  input  logic                       all_pixels_in,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       err_overflow,
  output logic                       err_underflow
);

  localparam int unsigned NBEATS = (META_W + DATA_W - 1) / DATA_W;
  localparam int unsigned SW     = NBEATS * DATA_W;
  localparam int unsigned PAD    = SW - META_W;
`ifdef IMG_META_CRC_EN
  localparam int unsigned TOTAL  = NBEATS + 1;
`else
  localparam int unsigned TOTAL  = NBEATS;
`endif
  localparam int unsigned LW     = TOTAL * DATA_W;
  localparam int unsigned BW     = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int unsigned CW     = $clog2(DEPTH + 1);

  state_e            state_q, state_d;
  logic [LW-1:0]     sreg_q, sreg_d, load_word;
  logic [SW-1:0]     padded;
  logic [BW-1:0]     beat_q, beat_d;
  logic [CW-1:0]     pend_q, pend_d, fifo_cnt;
  logic              prev_q, ovf_q, unf_q;
  logic              fifo_full, fifo_empty;
  logic [META_W-1:0] head;
  logic              req, req_ok, outstanding, last_beat, hs, load;

  img_meta_fifo #(
    .WIDTH (META_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .sysClk (sysClk),
    .rst    (rst),
    .push   (meta_valid),
    .wdata  (meta_in),
    .pop    (load),
    .rdata  (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_cnt)
  );

  // Only the registered count is used, so a header pushed this cycle cannot be claimed yet.
  assign req         = all_pixels_in & ~prev_q;
  assign req_ok      = req && (pend_q < fifo_cnt);
  assign outstanding = (pend_q != '0) || req_ok;
  assign last_beat   = (beat_q == BW'(TOTAL - 1));
  assign hs          = out_valid && out_ready;

  always_comb begin
    padded = SW'(head) << PAD;
`ifdef IMG_META_CRC_EN
    load_word = {padded, {DATA_W{1'b0}}};
    for (int i = 0; i < int'(NBEATS); i++) begin
      load_word[DATA_W-1:0] = load_word[DATA_W-1:0] ^ padded[i*DATA_W +: DATA_W];
    end
`else
    load_word = padded;
`endif
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    beat_d  = beat_q;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (outstanding && !fifo_empty) begin
          load    = 1'b1;
          state_d = StSend;
        end
      end
      StSend: begin
        if (hs) begin
          if (!last_beat) begin
            sreg_d = sreg_q << DATA_W;
            beat_d = beat_q + BW'(1);
          end else if (outstanding && !fifo_empty) begin
            load = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (load) begin
      sreg_d = load_word;
      beat_d = '0;
    end
  end

  assign pend_d = pend_q + CW'(req_ok) - CW'(load);

  always_ff @(posedge sysClk) begin
    if (rst) begin
      state_q <= StIdle;
      sreg_q  <= '0;
      beat_q  <= '0;
      pend_q  <= '0;
      prev_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      beat_q  <= beat_d;
      pend_q  <= pend_d;
      prev_q  <= all_pixels_in;
      if (meta_valid && fifo_full && !load) ovf_q <= 1'b1;
      if (req && !req_ok)                   unf_q <= 1'b1;
    end
  end

  assign out_valid     = (state_q == StSend);
  assign out_last      = out_valid && last_beat;
  assign out_data      = sreg_q[LW-1 -: DATA_W];
  assign fifo_count    = fifo_cnt;
  assign err_overflow  = ovf_q;
  assign err_underflow = unf_q;

endmodule

// File: tb/tb_img_metadata_serializer.sv
// Self-checking bench: directed table, corner-case sequences and random traffic vs a queue model.
module tb_img_metadata_serializer;
  import img_meta_pkg::*;

  localparam int unsigned DW    = 12;
  localparam int unsigned MW    = 48;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned NB    = (MW + DW - 1) / DW;
`ifdef IMG_META_CRC_EN
  localparam int unsigned TOTAL = NB + 1;
`else
  localparam int unsigned TOTAL = NB;
`endif
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          sysClk = 1'b0;
  logic          rst = 1'b1;
  logic [MW-1:0] meta_in = '0;
  logic          meta_valid = 1'b0;
  logic          all_pixels_in = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_last;
  logic [CW-1:0] fifo_count;
  logic          err_overflow;
  logic          err_underflow;

  always #5 sysClk = ~sysClk;

  img_metadata_serializer #(
    .DATA_W (DW),
    .META_W (MW),
    .DEPTH  (DEPTH)
  ) dut (
    .sysClk        (sysClk),
    .rst           (rst),
    .meta_in       (meta_in),
    .meta_valid    (meta_valid),
    .all_pixels_in (all_pixels_in),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last      (out_last),
    .fifo_count    (fifo_count),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a header queue, a count of claimed flushes, and the beats being sent.
  logic [MW-1:0] m_q[$];
  int            m_pend;
  bit            m_send;
  int            m_idx;
  logic [DW-1:0] m_beats[TOTAL];
  bit            m_prev, m_ovf, m_unf;

  function automatic void make_beats(input logic [MW-1:0] h);
    logic [NB*DW-1:0] p;
    p = (NB * DW)'(h) << (NB * DW - MW);
    for (int i = 0; i < int'(NB); i++) m_beats[i] = p[(int'(NB) - 1 - i) * int'(DW) +: DW];
`ifdef IMG_META_CRC_EN
    m_beats[NB] = '0;
    for (int i = 0; i < int'(NB); i++) m_beats[NB] = m_beats[NB] ^ m_beats[i];
`endif
  endfunction

  task automatic step(input bit r, input bit mv, input logic [MW-1:0] md, input bit api,
                      input bit rdy);
    int            cnt;
    bit            req, rok, hs, ld, lastb;
    logic [MW-1:0] h;
    rst = r; meta_valid = mv; meta_in = md; all_pixels_in = api; out_ready = rdy;
    if (r) begin
      m_q.delete();
      m_pend = 0; m_send = 0; m_idx = 0; m_prev = 0; m_ovf = 0; m_unf = 0;
    end else begin
      cnt   = m_q.size();
      req   = api && !m_prev;
      rok   = req && (m_pend < cnt);
      if (req && !rok) m_unf = 1;
      hs    = m_send && rdy;
      lastb = (m_idx == int'(TOTAL) - 1);
      ld    = ((!m_send) || (hs && lastb)) && (m_pend + int'(rok) > 0) && (cnt > 0);
      if (hs && !lastb) m_idx++;
      else if (hs && !ld) m_send = 0;
      if (ld) begin
        h = m_q.pop_front();
        make_beats(h);
        m_idx = 0;
        m_send = 1;
      end
      if (mv) begin
        if (cnt == int'(DEPTH) && !ld) m_ovf = 1;
        else m_q.push_back(md);
      end
      m_pend = m_pend + int'(rok) - int'(ld);
      m_prev = api;
    end
    @(posedge sysClk);
    #1;
    check("model_valid", out_valid, m_send);
    if (m_send) begin
      check("model_data", out_data, m_beats[m_idx]);
      check("model_last", out_last, (m_idx == int'(TOTAL) - 1));
    end else begin
      check("model_last_idle", out_last, 0);
    end
    check("model_count", fifo_count, m_q.size());
    check("model_ovf", err_overflow, m_ovf);
    check("model_unf", err_underflow, m_unf);
  endtask

  typedef struct {
    bit            mv;
    logic [MW-1:0] md;
    bit            api;
    bit            rdy;
    bit            ev;
    logic [DW-1:0] ed;
    bit            el;
    int            ecnt;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit mv, input logic [MW-1:0] md, input bit api, input bit rdy,
                              input bit ev, input logic [DW-1:0] ed, input bit el, input int ecnt);
    vec_t v;
    v.mv = mv; v.md = md; v.api = api; v.rdy = rdy;
    v.ev = ev; v.ed = ed; v.el = el; v.ecnt = ecnt;
    tbl.push_back(v);
  endfunction

  localparam logic [MW-1:0] HDR = 48'hABC123456789;

  initial begin
    int            nvalid;
    bit            api_lvl;
    logic [MW-1:0] md;

    // Basic burst: push, edge, four beats MSB-first, last flag on the final beat.
    add(1, HDR, 0, 1, 0, 12'h000, 0, 1);
    add(0, '0,  1, 1, 1, 12'hABC, 0, 0);
    add(0, '0,  1, 1, 1, 12'h123, 0, 0);
    add(0, '0,  0, 1, 1, 12'h456, 0, 0);
`ifdef IMG_META_CRC_EN
    add(0, '0,  0, 1, 1, 12'h789, 0, 0);
    add(0, '0,  0, 1, 1, 12'hABC ^ 12'h123 ^ 12'h456 ^ 12'h789, 1, 0);
`else
    add(0, '0,  0, 1, 1, 12'h789, 1, 0);
`endif
    add(0, '0,  0, 1, 0, 12'h000, 0, 0);

    step(1, 0, '0, 0, 0);
    step(1, 0, '0, 0, 0);
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_data", out_data, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ovf", err_overflow, 0);
    check("rst_unf", err_underflow, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(0, tbl[i].mv, tbl[i].md, tbl[i].api, tbl[i].rdy);
      check("tbl_valid", out_valid, tbl[i].ev);
      if (tbl[i].ev) check("tbl_data", out_data, tbl[i].ed);
      check("tbl_last", out_last, tbl[i].el);
      check("tbl_count", fifo_count, tbl[i].ecnt);
    end

    // Stall on beat 2 for three cycles.
    step(0, 1, HDR, 0, 1);
    step(0, 0, '0, 1, 1);
    step(0, 0, '0, 0, 1);
    step(0, 0, '0, 0, 1);
    check("stall_beat2", out_data, 12'h456);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, '0, 0, 0);
      check("stall_hold_data", out_data, 12'h456);
      check("stall_hold_valid", out_valid, 1);
    end
    for (int i = 0; i < int'(TOTAL); i++) step(0, 0, '0, 0, 1);
    check("stall_done", out_valid, 0);

    // Two headers, two edges two cycles apart: contiguous beats.
    step(0, 1, 48'h111222333444, 0, 1);
    step(0, 1, 48'h555666777888, 0, 1);
    nvalid = 0;
    step(0, 0, '0, 1, 1); nvalid += int'(out_valid);
    step(0, 0, '0, 0, 1); nvalid += int'(out_valid);
    step(0, 0, '0, 1, 1); nvalid += int'(out_valid);
    for (int i = 0; i < 2 * int'(TOTAL); i++) begin
      step(0, 0, '0, 0, 1);
      nvalid += int'(out_valid);
    end
    check("b2b_beats", nvalid, 2 * TOTAL);

    // Overflow: five pushes into a depth-4 queue, then drain with edges.
    for (int i = 0; i < 5; i++) step(0, 1, MW'(48'h100000000001 * (i + 1)), 0, 1);
    check("ovf_flag", err_overflow, 1);
    check("ovf_count", fifo_count, 4);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, '0, 1, 1);
      for (int j = 0; j < int'(TOTAL) + 1; j++) step(0, 0, '0, 0, 1);
    end
    check("ovf_drain_unf", err_underflow, 1);
    check("ovf_drain_idle", out_valid, 0);

    // Underflow from reset, and a later push alone does nothing.
    step(1, 0, '0, 0, 1);
    step(0, 0, '0, 1, 1);
    check("unf_flag", err_underflow, 1);
    check("unf_valid", out_valid, 0);
    step(0, 1, HDR, 1, 1);
    for (int i = 0; i < 5; i++) step(0, 0, '0, 1, 1);
    check("unf_push_only", out_valid, 0);

    // Reset mid-burst after beat 1.
    step(1, 0, '0, 0, 1);
    step(0, 1, HDR, 0, 1);
    step(0, 1, 48'h0F0F0F0F0F0F, 1, 1);
    step(0, 0, '0, 0, 1);
    check("mid_beat1", out_data, 12'h123);
    step(1, 0, '0, 0, 1);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_count", fifo_count, 0);
    step(0, 0, '0, 1, 1);
    check("mid_rst_no_resume", out_valid, 0);

    // Random traffic against the model.
    step(1, 0, '0, 0, 1);
    api_lvl = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) api_lvl = !api_lvl;
      md = MW'({$urandom(), $urandom()});
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 3) == 0), md, api_lvl,
           ($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
